// File: rtl/run_ctrl_pkg.sv
// Shared types and defaults for the run controller.
package run_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RST  = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } run_state_t;

  localparam int DEF_NUM_CORES  = 1;
  localparam int DEF_RST_CYCLES = 2;
  localparam int DEF_MAX_CYCLES = 20;
  localparam int DEF_CNT_W      = 16;

endpackage

// File: rtl/run_ctrl_if.sv
// Control/status bundle between a run supervisor and its requester.
interface run_ctrl_if
  import run_pkg::*;
#(
  parameter int NUM_CORES = DEF_NUM_CORES,
  parameter int CNT_W     = DEF_CNT_W
) ();

  logic                 start;
  logic [NUM_CORES-1:0] halt;
  logic [NUM_CORES-1:0] core_err;
  logic                 core_reset;
  logic                 busy;
  logic                 done;
  logic                 timeout;
  logic                 err;
  logic [NUM_CORES-1:0] halted_mask;
  logic [CNT_W-1:0]     cycle_count;

  modport master (
    output start, halt, core_err,
    input  core_reset, busy, done, timeout, err, halted_mask, cycle_count
  );

  modport slave (
    input  start, halt, core_err,
    output core_reset, busy, done, timeout, err, halted_mask, cycle_count
  );

endinterface

// File: rtl/run_ctrl_sat_counter.sv
// Up-counter with synchronous clear that sticks at all-ones.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_en,
  input  logic         i_clr,
  output logic [W-1:0] o_cnt
);

  logic [W-1:0] r_cnt;

  // Clear wins over count; counting stops once the value saturates.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en && (r_cnt != '1)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/run_ctrl.sv
// Run supervisor: holds cores in reset, releases them for a run, and
// records how the run ended (all halted, core error, cycle budget).
//
//   state | meaning
//   IDLE  | cores held in reset, waiting for start
//   RST   | cores held in reset for RST_CYCLES clocks before release
//   RUN   | cores running, cycle budget counting, halts/errors tracked
//   DONE  | cores held in reset, result flags and count frozen
module run_ctrl
  import run_pkg::*;
#(
  parameter int NUM_CORES  = DEF_NUM_CORES,
  parameter int RST_CYCLES = DEF_RST_CYCLES,
  parameter int MAX_CYCLES = DEF_MAX_CYCLES,
  parameter int CNT_W      = DEF_CNT_W
) (
  input  logic       clk,
  input  logic       reset,
  run_ctrl_if.slave  io_run
);

  localparam logic [7:0]       RST_LOAD = 8'(RST_CYCLES - 1);
  localparam bit               TO_EN    = (MAX_CYCLES != 0);
  localparam logic [CNT_W-1:0] TC_VAL   = TO_EN ? CNT_W'(MAX_CYCLES - 1) : '0;

  run_state_t           r_state;
  run_state_t           w_next;
  logic [7:0]           r_rst_cnt;
  logic                 r_timeout;
  logic                 r_err;
  logic [NUM_CORES-1:0] r_halted;
  logic                 w_launch;
  logic                 w_rst_tc;
  logic                 w_run;
  logic                 w_any_err;
  logic                 w_all_halt;
  logic                 w_to_hit;
  logic [CNT_W-1:0]     w_cnt;

  // Next-state decode and run exit conditions; halt/core_err only matter in RUN.
  always_comb begin
    w_next     = r_state;
    w_launch   = 1'b0;
    w_run      = 1'b0;
    w_any_err  = 1'b0;
    w_all_halt = 1'b0;
    w_to_hit   = 1'b0;
    w_rst_tc   = (r_rst_cnt == 8'd0);
    case (r_state)
      IDLE, DONE: begin
        if (io_run.start) begin
          w_launch = 1'b1;
          w_next   = RST;
        end
      end
      RST: begin
        if (w_rst_tc) w_next = RUN;
      end
      RUN: begin
        w_run      = 1'b1;
        w_any_err  = |io_run.core_err;
        w_all_halt = &(r_halted | io_run.halt);
        // Compare the pre-increment count so the exit cycle is included.
        w_to_hit   = TO_EN && (w_cnt == TC_VAL);
        if (w_any_err || w_all_halt || w_to_hit) w_next = DONE;
      end
      default: w_next = IDLE;
    endcase
  end

  // State register and RST hold-off down-counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= IDLE;
      r_rst_cnt <= 8'd0;
    end else begin
      r_state <= w_next;
      if (w_launch) begin
        r_rst_cnt <= RST_LOAD;
      end else if ((r_state == RST) && !w_rst_tc) begin
        r_rst_cnt <= r_rst_cnt - 8'd1;
      end
    end
  end

  // Sticky result flags: cleared on launch, accumulated only while running.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_timeout <= 1'b0;
      r_err     <= 1'b0;
      r_halted  <= '0;
    end else if (w_launch) begin
      r_timeout <= 1'b0;
      r_err     <= 1'b0;
      r_halted  <= '0;
    end else if (w_run) begin
      r_halted <= r_halted | io_run.halt;
      if (w_any_err) r_err     <= 1'b1;
      if (w_to_hit)  r_timeout <= 1'b1;
    end
  end

  sat_counter #(
    .W (CNT_W)
  ) u_cycle_cnt (
    .clk   (clk),
    .rst_n (reset),
    .i_en  (w_run),
    .i_clr (w_launch),
    .o_cnt (w_cnt)
  );

  assign io_run.core_reset  = (r_state != RUN);
  assign io_run.busy        = (r_state == RST) || (r_state == RUN);
  assign io_run.done        = (r_state == DONE);
  assign io_run.timeout     = r_timeout;
  assign io_run.err         = r_err;
  assign io_run.halted_mask = r_halted;
  assign io_run.cycle_count = w_cnt;

endmodule

// File: tb/tb_run_ctrl.sv
// Directed scoreboard bench for run_ctrl: stimulus pushes the expected
// end-of-run result, a monitor pops it when done rises.
module tb_run_ctrl;
  import run_pkg::*;

  localparam int NC = 2;
  localparam int RC = 2;
  localparam int MC = 20;
  localparam int CW = 16;

  typedef struct {
    logic          timeout;
    logic          err;
    logic [NC-1:0] mask;
    logic [CW-1:0] cnt;
    string         name;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  run_ctrl_if #(.NUM_CORES(NC), .CNT_W(CW)) u_if ();

  run_ctrl #(
    .NUM_CORES  (NC),
    .RST_CYCLES (RC),
    .MAX_CYCLES (MC),
    .CNT_W      (CW)
  ) u_dut (
    .clk    (clk),
    .reset  (reset),
    .io_run (u_if)
  );

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   rc    = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic push_exp(logic to, logic er, logic [NC-1:0] m, logic [CW-1:0] c, string nm);
    exp_t e;
    e.timeout = to; e.err = er; e.mask = m; e.cnt = c; e.name = nm;
    q.push_back(e);
  endtask

  task automatic pulse_start();
    u_if.start = 1'b1;
    @(negedge clk);
    u_if.start = 1'b0;
  endtask

  // Returns at the negedge inside run cycle 1.
  task automatic wait_run(string nm);
    for (int i = 0; i < 50; i++) begin
      if (u_if.busy && !u_if.core_reset) begin
        rc = 1;
        return;
      end
      @(negedge clk);
    end
    n_cmp++; n_bad++;
    $display("FAIL %s_wait_run: RUN never reached, busy=%0b core_reset=%0b", nm, u_if.busy, u_if.core_reset);
  endtask

  task automatic wait_done(string nm);
    for (int i = 0; i < 80; i++) begin
      if (u_if.done) return;
      @(negedge clk);
    end
    n_cmp++; n_bad++;
    $display("FAIL %s_wait_done: done never rose, got 0 expected 1", nm);
  endtask

  task automatic goto_cycle(int k);
    while (rc < k) begin
      @(negedge clk);
      rc++;
    end
  endtask

  task automatic drive_at(int k, logic [NC-1:0] h, logic [NC-1:0] e);
    goto_cycle(k);
    u_if.halt = h; u_if.core_err = e;
    goto_cycle(k + 1);
    u_if.halt = '0; u_if.core_err = '0;
  endtask

  task automatic chk_reset_vals(string nm);
    chk({nm, ".core_reset"},  u_if.core_reset,  1);
    chk({nm, ".busy"},        u_if.busy,        0);
    chk({nm, ".done"},        u_if.done,        0);
    chk({nm, ".timeout"},     u_if.timeout,     0);
    chk({nm, ".err"},         u_if.err,         0);
    chk({nm, ".halted_mask"}, u_if.halted_mask, 0);
    chk({nm, ".cycle_count"}, u_if.cycle_count, 0);
  endtask

  // Monitor: RST length on every release, result fields on every done rise.
  initial begin
    int   rst_len;
    logic prev_done;
    logic prev_cr;
    exp_t e;
    rst_len = 0; prev_done = 1'b0; prev_cr = 1'b1;
    forever begin
      @(negedge clk);
      if (reset !== 1'b1) begin
        rst_len = 0; prev_done = 1'b0; prev_cr = 1'b1;
      end else begin
        if (!u_if.busy) begin
          rst_len = 0;
        end else if (u_if.core_reset) begin
          rst_len++;
        end else if (prev_cr) begin
          chk("rst_len", rst_len, RC);
          rst_len = 0;
        end
        if (u_if.done && !prev_done) begin
          if (q.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL unexpected_done: got done=1 expected no completion");
          end else begin
            e = q.pop_front();
            chk({e.name, ".timeout"},     u_if.timeout,     e.timeout);
            chk({e.name, ".err"},         u_if.err,         e.err);
            chk({e.name, ".halted_mask"}, u_if.halted_mask, e.mask);
            chk({e.name, ".cycle_count"}, u_if.cycle_count, e.cnt);
            chk({e.name, ".core_reset"},  u_if.core_reset,  1);
            chk({e.name, ".busy"},        u_if.busy,        0);
          end
        end
        prev_done = u_if.done;
        prev_cr   = u_if.core_reset;
      end
    end
  end

  initial begin
    reset = 1'b0;
    u_if.start = 1'b0; u_if.halt = '0; u_if.core_err = '0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk_reset_vals("por");
    #2 reset = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle.core_reset", u_if.core_reset, 1);
    chk("idle.busy",       u_if.busy,       0);

    // Run A: no halts, ends on the 20-cycle budget.
    pulse_start();
    push_exp(1'b1, 1'b0, 2'b00, 16'd20, "runA");
    chk("runA_rst.core_reset", u_if.core_reset, 1);
    chk("runA_rst.busy",       u_if.busy,       1);
    wait_run("runA");
    chk("runA_run.core_reset",  u_if.core_reset,  0);
    chk("runA_run.busy",        u_if.busy,        1);
    chk("runA_run.cycle_count", u_if.cycle_count, 0);
    wait_done("runA");

    // Run B: relaunch from DONE; halts at cycles 3 and 7; start mid-run ignored.
    pulse_start();
    push_exp(1'b0, 1'b0, 2'b11, 16'd7, "runB");
    chk("runB_rst.timeout",     u_if.timeout,     0);
    chk("runB_rst.cycle_count", u_if.cycle_count, 0);
    chk("runB_rst.done",        u_if.done,        0);
    wait_run("runB");
    drive_at(3, 2'b01, 2'b00);
    goto_cycle(5);
    u_if.start = 1'b1;
    goto_cycle(6);
    u_if.start = 1'b0;
    drive_at(7, 2'b10, 2'b00);
    wait_done("runB");

    // Run C: error, final halt and budget expiry all on run cycle 20.
    pulse_start();
    push_exp(1'b1, 1'b1, 2'b11, 16'd20, "runC");
    wait_run("runC");
    drive_at(5, 2'b01, 2'b00);
    drive_at(20, 2'b10, 2'b01);
    wait_done("runC");

    // Run D: halt/err during RST ignored; core error at cycle 3.
    pulse_start();
    push_exp(1'b0, 1'b1, 2'b01, 16'd3, "runD");
    u_if.halt = 2'b10; u_if.core_err = 2'b01;
    wait_run("runD");
    u_if.halt = '0; u_if.core_err = '0;
    drive_at(2, 2'b01, 2'b00);
    drive_at(3, 2'b00, 2'b10);
    wait_done("runD");

    // Run E: reset at run cycle 5 aborts; fresh run afterwards.
    pulse_start();
    wait_run("runE");
    drive_at(2, 2'b01, 2'b00);
    goto_cycle(5);
    #2 reset = 1'b0;
    #1 chk_reset_vals("abort");
    repeat (3) @(negedge clk);
    chk("abort_hold.busy", u_if.busy, 0);
    #2 reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_abort.done",       u_if.done,       0);
    chk("post_abort.core_reset", u_if.core_reset, 1);
    pulse_start();
    push_exp(1'b0, 1'b0, 2'b11, 16'd4, "runF");
    wait_run("runF");
    chk("runF_run.cycle_count", u_if.cycle_count, 0);
    drive_at(4, 2'b11, 2'b00);
    wait_done("runF");

    repeat (3) @(negedge clk);
    chk("queue_empty", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/run_ctrl.md
RUN_CTRL -- requirements
Module: run_ctrl

Interface
REQ-001 Parameter NUM_CORES, default 1, meaning number of processor cores supervised.
REQ-002 Parameter RST_CYCLES, default 2, meaning clk cycles core_reset is held high after start; legal range 1..255.
REQ-003 Parameter MAX_CYCLES, default 20, meaning run-phase cycle budget; 0 disables timeout.
REQ-004 Parameter CNT_W, default 16, meaning cycle_count width; MAX_CYCLES SHALL be at most 2^CNT_W-1.
REQ-005 clk  input  1  single system clock, all state on rising edge.
REQ-006 reset  input  1  asynchronous, active-low block reset (asserted when 0).
REQ-007 start  input  1  one-cycle request to launch or relaunch a run.
REQ-008 halt  input  NUM_CORES  per-core halt indication, level.
REQ-009 core_err  input  NUM_CORES  per-core error/invalid-instruction indication, level.
REQ-010 core_reset  output  1  active-high reset driven to all cores.
REQ-011 busy  output  1  high in RST and RUN states.
REQ-012 done  output  1  high in DONE state.
REQ-013 timeout  output  1  sticky, run ended by cycle budget.
REQ-014 err  output  1  sticky, run ended by a core error.
REQ-015 halted_mask  output  NUM_CORES  sticky OR of halt bits seen during RUN.
REQ-016 cycle_count  output  CNT_W  RUN cycles elapsed in the current/last run.

Function
REQ-017 FSM states SHALL be IDLE, RST, RUN, DONE.
REQ-018 IDLE: core_reset=1; start=1 -> RST next cycle, clearing timeout, err, halted_mask, cycle_count.
REQ-019 RST: core_reset=1 for exactly RST_CYCLES cycles, then RUN; start ignored.
REQ-020 RUN: core_reset=0; cycle_count increments by 1 every cycle, saturating at 2^CNT_W-1.
REQ-021 RUN: halted_mask <= halted_mask | halt each cycle.
REQ-022 RUN exit to DONE when any core_err bit is 1 (sets err), or (halted_mask | halt) is all ones (normal finish), or MAX_CYCLES!=0 and cycle_count==MAX_CYCLES-1 (sets timeout).
REQ-023 Simultaneous exit conditions SHALL all be recorded in the same cycle (err and timeout may both be 1); exit occurs once.
REQ-024 cycle_count SHALL include the exit cycle (timeout run ends with cycle_count==MAX_CYCLES).
REQ-025 DONE: core_reset=1, done=1, flags and counters frozen; start=1 -> RST with clears per REQ-018.
REQ-026 start in RST or RUN SHALL have no effect.
REQ-027 halt/core_err outside RUN SHALL be ignored.
REQ-028 All outputs SHALL be registered or decoded from state only; no input-to-output combinational path.

Reset
REQ-029 reset=0 SHALL immediately (asynchronously) force state IDLE, core_reset=1, busy=0, done=0, timeout=0, err=0, halted_mask=0, cycle_count=0.
REQ-030 reset asserted mid-run SHALL abort without setting any flag; release returns to IDLE awaiting start.
REQ-031 The internal RST_CYCLES down-counter SHALL reset to 0.

Structure
REQ-032 Shared package run_pkg SHALL hold the FSM state encoding (2 bits: IDLE=0, RST=1, RUN=2, DONE=3) and default parameter constants.
REQ-033 One sub-module, sat_counter (parametrised width, enable, clear, saturate), SHALL implement cycle_count.
REQ-034 The block SHALL be synthesisable; no delays or simulation-only constructs.

Verification
REQ-035 NUM_CORES=1, RST_CYCLES=2: reset low 10 clk, release, start pulse -> core_reset high exactly 2 cycles, then busy=1, core_reset=0.
REQ-036 MAX_CYCLES=20, halt never asserted -> done=1, timeout=1, err=0, cycle_count=20.
REQ-037 NUM_CORES=2, halt[0] pulsed at run cycle 3, halt[1] at cycle 7 -> done at cycle 7, halted_mask=2'b11, timeout=0, cycle_count=7.
REQ-038 core_err[0] and final halt in the same cycle, which is also cycle 20 with MAX_CYCLES=20 -> err=1, timeout=1, done=1, halted_mask=all ones.
REQ-039 reset low at run cycle 5 -> outputs immediately match REQ-029; no done; after release and start, fresh run with cycle_count from 0.
REQ-040 start in DONE after a timeout run -> flags clear, RST repeats 2 cycles, second run completes independently.
